sha256_stream_padder: RTL and testbench
=======================================

// Module: sha256_stream_padder
// PURPOSE
//  Streaming SHA-256 pre-processor: accepts message bytes in IN_BYTES-wide beats, appends 0x80, zero fill
//  and the 64-bit big-endian bit length, and emits each 512-bit block as 16 32-bit words over valid/ready.
//  Single 64-byte block buffer, so message length is unbounded (no whole-message RAM). Sits between the
//  host byte stream and the compression core; the core consumes words in order, with first/last block flags.
// PARAMETERS
//  IN_BYTES  1   bytes per input beat; legal 1,2,4,8 (64 % IN_BYTES == 0, so a beat never spans blocks)
//  LEN_W     64  internal bit-length counter width, 16..64; zero-extended into the 64-bit length field
// PORTS
//  clk           in   1              clock
//  rst_n         in   1              reset, asynchronous, active-low
//  s_valid       in   1              input beat valid
//  s_ready       out  1              padder accepts beat (transfer = s_valid & s_ready)
//  s_data        in   8*IN_BYTES     lane 0 = s_data[7:0] = earliest byte
//  s_nbytes      in   clog2(IN_BYTES+1)  valid lanes, low lanes first; must equal IN_BYTES unless s_last
//  s_last        in   1              final beat of message; s_nbytes==0 legal only here (empty tail)
//  m_valid       out  1              output word valid
//  m_ready       in   1              core accepts word
//  m_word        out  32             big-endian word: buffer byte 4k -> [31:24]
//  m_word_idx    out  4              word index 0..15 within block
//  m_first_blk   out  1              current block is the message's first
//  m_last_blk    out  1              current block is the message's last (carries length field)
//  busy          out  1              message in progress (first beat accepted .. last word accepted)
//  err_len_ovf   out  1              sticky: LEN_W bit counter wrapped; cleared on next message's first beat
// BEHAVIOUR
//  Reset: state IDLE; s_ready=1, m_valid=0, m_word=0, m_word_idx=0, flags/busy/err=0. Reset mid-message
//   discards everything; no partial block is ever emitted afterwards.
//  States: IDLE -> FILL (first beat) ; FILL -> DRAIN when byte_ptr reaches 64 ; FILL -> PAD80 on s_last
//   transfer ; PAD80 writes 0x80, one cycle -> PAD0 ; PAD0 writes 0x00/cycle until ptr==56 -> LEN, or
//   until ptr==64 -> DRAIN (then PAD0 again for extra block) ; LEN writes 8 length bytes MSB first -> DRAIN
//   with last flag ; DRAIN emits words 0..15 ; after word 15 accepted -> FILL, PAD0 or IDLE (last block).
//  Full block of data ending exactly on s_last: DRAIN non-last block, then PAD80 on a fresh block.
//  s_ready=1 only in IDLE/FILL; 0 during padding, length, DRAIN. Beat writes s_nbytes bytes in one cycle.
//  m_valid rises the cycle after DRAIN entry (1-cycle buffer read); m_word/idx/flags held stable while
//   m_valid & !m_ready; next word valid the cycle after each handshake when m_ready stays high (1 word/clk).
//  Length: bit_cnt += 8*s_nbytes per transfer, mod 2^LEN_W; wrap sets err_len_ovf; field = zext64(bit_cnt).
//  Empty message (s_last, s_nbytes=0 as first beat): one block 0x80000000, zeros, length 0.
//  Simultaneous m_ready with DRAIN exit and s_valid: beat not accepted until the FILL cycle (no bypass).
//  s_nbytes>IN_BYTES or nbytes<IN_BYTES without s_last: undefined input; bench must not drive.
// CONFIGURATION
//  SHA_PAD_RAW_EN: adds input raw_mode (1b, sampled with first beat of message) and output err_raw_align.
//   raw_mode=1: no 0x80/zero/length insertion; blocks emitted as received; message must total 64*k bytes;
//   tail not 64-aligned -> zero-filled, emitted with m_last_blk, err_raw_align=1 (sticky until next msg).
//   Undefined: raw_mode ignored-port absent, padding always applied.
// STRUCTURE
//  Package sha_pad_pkg: state enum pad_state_t {IDLE,FILL,PAD80,PAD0,LEN,DRAIN}; localparams
//   BLOCK_BYTES=64, LEN_FIELD_BYTES=8, PAD_LIMIT=56, WORDS_PER_BLOCK=16.
//  Sub-module sha_block_buf: 64x8 byte-lane write (up to IN_BYTES lanes/cycle), registered 32-bit read.
// TESTING
//  "abc", IN_BYTES=1 -> one block: w0=0x61626380, w1..w14=0, w15=0x00000018, first=last=1.
//  55 bytes 0x00 -> single block, w13=0x00000080, w15=0x000001B8; 56 bytes -> two blocks, blk2 w15=0x1C0.
//  64 bytes 0xFF -> blk1 all 0xFFFFFFFF (last=0); blk2 w0=0x80000000, w15=0x00000200, last=1.
//  Empty message -> w0=0x80000000, rest 0, m_first_blk=m_last_blk=1; busy drops after word 15.
//  IN_BYTES=4, beat "abc" s_nbytes=3 s_last=1 -> same block as case 1; m_ready random 50% -> identical words.
//  LEN_W=16, 8192 bytes -> err_len_ovf=1, length field 0; rst_n pulse mid-DRAIN -> m_valid=0 next edge.

Source files
------------

// File: rtl/sha_pad_pkg.sv
// rtl/sha_pad_pkg.sv - shared types and block geometry for the SHA-256 stream padder
package sha_pad_pkg;
    typedef enum logic [2:0] {IDLE, FILL, PAD80, PAD0, LEN, DRAIN} pad_state_t;

    localparam int BLOCK_BYTES     = 64;
    localparam int LEN_FIELD_BYTES = 8;
    localparam int PAD_LIMIT       = 56;
    localparam int WORDS_PER_BLOCK = 16;

    // Byte sel of the big-endian length field; sel 0 is the most significant byte.
    function automatic logic [7:0] len_byte(input logic [63:0] len, input logic [2:0] sel);
        return 8'(len >> (8 * (LEN_FIELD_BYTES - 1 - int'(sel))));
    endfunction
endpackage

// File: rtl/sha256_stream_padder_if.sv
// rtl/sha256_stream_padder_if.sv - byte-beat input stream and 32-bit word output stream of the padder
interface sha256_stream_padder_if #(parameter int IN_BYTES = 1);
    localparam int NB_W = $clog2(IN_BYTES + 1);

    logic                  s_valid;
    logic                  s_ready;
    logic [8*IN_BYTES-1:0] s_data;
    logic [NB_W-1:0]       s_nbytes;
    logic                  s_last;
    logic                  m_valid;
    logic                  m_ready;
    logic [31:0]           m_word;
    logic [3:0]            m_word_idx;
    logic                  m_first_blk;
    logic                  m_last_blk;

    modport slave (
        input  s_valid, s_data, s_nbytes, s_last, m_ready,
        output s_ready, m_valid, m_word, m_word_idx, m_first_blk, m_last_blk
    );
    modport master (
        output s_valid, s_data, s_nbytes, s_last, m_ready,
        input  s_ready, m_valid, m_word, m_word_idx, m_first_blk, m_last_blk
    );
endinterface

// File: rtl/sha_block_buf.sv
// rtl/sha_block_buf.sv - 64-byte block buffer: multi-lane byte write, registered big-endian word read
module sha_block_buf
    import sha_pad_pkg::*;
#(
    parameter int IN_BYTES = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [5:0]                       wr_ptr,
    input  logic [8*IN_BYTES-1:0]            wr_data,
    input  logic [$clog2(IN_BYTES+1)-1:0]    wr_nbytes,
    input  logic                             rd_en,
    input  logic [3:0]                       rd_idx,
    output logic [31:0]                      rd_word
);
    logic [7:0]  mem_q [BLOCK_BYTES];
    logic [31:0] rd_word_q, rd_word_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < IN_BYTES; i++) begin
                if (i < int'(wr_nbytes)) begin
                    mem_q[wr_ptr + 6'(i)] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word_d = rd_word_q;
        if (rd_en) begin
            rd_word_d = {mem_q[{rd_idx, 2'd0}], mem_q[{rd_idx, 2'd1}],
                         mem_q[{rd_idx, 2'd2}], mem_q[{rd_idx, 2'd3}]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_word_q <= '0;
        else        rd_word_q <= rd_word_d;
    end

    assign rd_word = rd_word_q;
endmodule

// File: rtl/sha256_stream_padder.sv
// rtl/sha256_stream_padder.sv - streaming SHA-256 message padder, one 64-byte block in flight
// Optional raw pass-through mode: SHA_PAD_RAW_EN
module sha256_stream_padder
    import sha_pad_pkg::*;
#(
    parameter int IN_BYTES = 1,
    parameter int LEN_W    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sha256_stream_padder_if.slave  io,
`ifdef SHA_PAD_RAW_EN
    input  logic                   raw_mode,
    output logic                   err_raw_align,
`endif
    output logic                   busy,
    output logic                   err_len_ovf
);
    localparam int         NB_W      = $clog2(IN_BYTES + 1);
    localparam logic [6:0] BLK_END   = 7'(BLOCK_BYTES);
    localparam logic [6:0] LEN_START = 7'(PAD_LIMIT);
    localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_BLOCK - 1);

    pad_state_t         state_q, state_d, resume_q, resume_d;
    logic [6:0]         ptr_q, ptr_d, ptr_beat;
    logic [4:0]         rd_ptr_q, rd_ptr_d;
    logic [3:0]         idx_q, idx_d;
    logic               m_valid_q, m_valid_d, first_q, first_d, last_q, last_d;
    logic               busy_q, busy_d, s_ready_q, s_ready_d, ovf_q, ovf_d;
    logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d, bit_base;
    logic [LEN_W:0]     bit_sum;
    logic               xfer, hs, raw_now, wr_en, wr_pad, rd_en;
    logic [7:0]         pad_byte;
    logic [31:0]        rd_word;

`ifdef SHA_PAD_RAW_EN
    logic raw_q, raw_d, raw_err_q, raw_err_d;
    assign raw_now       = (state_q == IDLE) ? raw_mode : raw_q;
    assign err_raw_align = raw_err_q;
`else
    assign raw_now = 1'b0;
`endif

    assign xfer     = io.s_valid && s_ready_q;
    assign hs       = m_valid_q && io.m_ready;
    assign ptr_beat = ptr_q + 7'(io.s_nbytes);
    assign bit_base = (state_q == IDLE) ? '0 : bit_cnt_q;
    assign bit_sum  = {1'b0, bit_base} + (LEN_W+1)'({io.s_nbytes, 3'b000});

    always_comb begin
        state_d   = state_q;   resume_d  = resume_q;  ptr_d  = ptr_q;
        rd_ptr_d  = rd_ptr_q;  idx_d     = idx_q;     m_valid_d = m_valid_q;
        first_d   = first_q;   last_d    = last_q;    bit_cnt_d = bit_cnt_q;
        ovf_d     = ovf_q;     wr_en     = 1'b0;      wr_pad    = 1'b0;
        pad_byte  = 8'h00;     rd_en     = 1'b0;
`ifdef SHA_PAD_RAW_EN
        raw_d     = raw_q;     raw_err_d = raw_err_q;
`endif
        case (state_q)
            IDLE, FILL: begin
                if (xfer) begin
                    wr_en     = 1'b1;
                    ptr_d     = ptr_beat;
                    bit_cnt_d = bit_sum[LEN_W-1:0];
                    if (state_q == IDLE) begin
                        first_d = 1'b1;
                        last_d  = 1'b0;
                        ovf_d   = 1'b0;
`ifdef SHA_PAD_RAW_EN
                        raw_d     = raw_mode;
                        raw_err_d = 1'b0;
`endif
                    end
                    if (bit_sum[LEN_W]) ovf_d = 1'b1;
                    if (ptr_beat == BLK_END) begin
                        state_d  = DRAIN;
                        resume_d = io.s_last ? PAD80 : FILL;
                        if (io.s_last && raw_now) begin
                            last_d   = 1'b1;
                            resume_d = IDLE;
                        end
                    end else if (io.s_last) begin
                        state_d = raw_now ? PAD0 : PAD80;
`ifdef SHA_PAD_RAW_EN
                        if (raw_now) raw_err_d = 1'b1;
`endif
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            PAD80: begin
                wr_en    = 1'b1;
                wr_pad   = 1'b1;
                pad_byte = 8'h80;
                ptr_d    = ptr_q + 7'd1;
                state_d  = PAD0;
            end
            PAD0: begin
                if (ptr_q == LEN_START && !raw_now) begin
                    state_d = LEN;
                end else if (ptr_q == BLK_END) begin
                    // No room left for the length: flush and pad a further block.
                    state_d  = DRAIN;
                    resume_d = PAD0;
                    if (raw_now) begin
                        last_d   = 1'b1;
                        resume_d = IDLE;
                    end
                end else begin
                    wr_en  = 1'b1;
                    wr_pad = 1'b1;
                    ptr_d  = ptr_q + 7'd1;
                end
            end
            LEN: begin
                wr_en    = 1'b1;
                wr_pad   = 1'b1;
                pad_byte = len_byte(64'(bit_cnt_q), ptr_q[2:0]);
                ptr_d    = ptr_q + 7'd1;
                if (ptr_q == BLK_END - 7'd1) begin
                    state_d  = DRAIN;
                    last_d   = 1'b1;
                    resume_d = IDLE;
                end
            end
            DRAIN: begin
                // Prefetch the next word on each handshake to sustain one word per clock.
                if (rd_ptr_q == 5'd0 || (hs && rd_ptr_q != 5'd16)) begin
                    rd_en     = 1'b1;
                    idx_d     = rd_ptr_q[3:0];
                    rd_ptr_d  = rd_ptr_q + 5'd1;
                    m_valid_d = 1'b1;
                end else if (hs) begin
                    m_valid_d = 1'b0;
                end
                if (hs && idx_q == LAST_WORD) begin
                    state_d  = resume_q;
                    ptr_d    = '0;
                    rd_ptr_d = '0;
                    first_d  = 1'b0;
                    last_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d    = (state_d != IDLE);
        s_ready_d = (state_d == IDLE) || (state_d == FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;  resume_q <= IDLE;  ptr_q <= '0;  rd_ptr_q <= '0;
            idx_q <= '0;  m_valid_q <= 1'b0;  first_q <= 1'b0;  last_q <= 1'b0;
            busy_q <= 1'b0;  s_ready_q <= 1'b1;  bit_cnt_q <= '0;  ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;  resume_q <= resume_d;  ptr_q <= ptr_d;  rd_ptr_q <= rd_ptr_d;
            idx_q <= idx_d;  m_valid_q <= m_valid_d;  first_q <= first_d;  last_q <= last_d;
            busy_q <= busy_d;  s_ready_q <= s_ready_d;  bit_cnt_q <= bit_cnt_d;  ovf_q <= ovf_d;
        end
    end

`ifdef SHA_PAD_RAW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q     <= 1'b0;
            raw_err_q <= 1'b0;
        end else begin
            raw_q     <= raw_d;
            raw_err_q <= raw_err_d;
        end
    end
`endif

    sha_block_buf #(.IN_BYTES(IN_BYTES)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_ptr    (ptr_q[5:0]),
        .wr_data   (wr_pad ? (8*IN_BYTES)'(pad_byte) : io.s_data),
        .wr_nbytes (wr_pad ? NB_W'(1) : io.s_nbytes),
        .rd_en     (rd_en),
        .rd_idx    (rd_ptr_q[3:0]),
        .rd_word   (rd_word)
    );

    assign io.s_ready     = s_ready_q;
    assign io.m_valid     = m_valid_q;
    assign io.m_word      = rd_word;
    assign io.m_word_idx  = idx_q;
    assign io.m_first_blk = first_q;
    assign io.m_last_blk  = last_q;
    assign busy           = busy_q;
    assign err_len_ovf    = ovf_q;
endmodule

// File: tb/tb_sha256_stream_padder.sv
// tb/tb_sha256_stream_padder.sv - directed-vector bench for sha256_stream_padder
`timescale 1ns/1ps
module tb_sha256_stream_padder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [37:0] obs_q [$];
    logic a_hold = 1'b0;
    logic a_busy, a_err, b_busy, b_err, c_busy, c_err;

    sha256_stream_padder_if #(.IN_BYTES(1)) a_if ();
    sha256_stream_padder_if #(.IN_BYTES(4)) b_if ();
    sha256_stream_padder_if #(.IN_BYTES(8)) c_if ();

`ifdef SHA_PAD_RAW_EN
    logic a_rerr, b_rerr, c_rerr;
`endif

    sha256_stream_padder #(.IN_BYTES(1), .LEN_W(64)) u_a (
        .clk(clk), .rst_n(rst_n), .io(a_if),
`ifdef SHA_PAD_RAW_EN
        .raw_mode(1'b0), .err_raw_align(a_rerr),
`endif
        .busy(a_busy), .err_len_ovf(a_err));
    sha256_stream_padder #(.IN_BYTES(4), .LEN_W(64)) u_b (
        .clk(clk), .rst_n(rst_n), .io(b_if),
`ifdef SHA_PAD_RAW_EN
        .raw_mode(1'b0), .err_raw_align(b_rerr),
`endif
        .busy(b_busy), .err_len_ovf(b_err));
    sha256_stream_padder #(.IN_BYTES(8), .LEN_W(16)) u_c (
        .clk(clk), .rst_n(rst_n), .io(c_if),
`ifdef SHA_PAD_RAW_EN
        .raw_mode(1'b0), .err_raw_align(c_rerr),
`endif
        .busy(c_busy), .err_len_ovf(c_err));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Words accepted by any core side; only one padder is active at a time.
    always @(negedge clk) begin
        if (a_if.m_valid && a_if.m_ready)
            obs_q.push_back({a_if.m_first_blk, a_if.m_last_blk, a_if.m_word_idx, a_if.m_word});
        if (b_if.m_valid && b_if.m_ready)
            obs_q.push_back({b_if.m_first_blk, b_if.m_last_blk, b_if.m_word_idx, b_if.m_word});
        if (c_if.m_valid && c_if.m_ready)
            obs_q.push_back({c_if.m_first_blk, c_if.m_last_blk, c_if.m_word_idx, c_if.m_word});
    end

    initial begin
        a_if.m_ready = 1'b0; b_if.m_ready = 1'b0; c_if.m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            a_if.m_ready = !a_hold;
            b_if.m_ready = 1'($urandom_range(0, 1));
            c_if.m_ready = 1'b1;
        end
    end

    task automatic send_a(input logic [7:0] d, input logic nb, input logic last);
        logic acc = 1'b0;
        a_if.s_valid = 1'b1; a_if.s_data = d; a_if.s_nbytes = nb; a_if.s_last = last;
        for (int t = 0; t < 2000 && !acc; t++) begin
            @(negedge clk); acc = a_if.s_ready;
            @(posedge clk); #1;
        end
        a_if.s_valid = 1'b0;
        if (!acc) check("a_send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic send_b(input logic [31:0] d, input logic [2:0] nb, input logic last);
        logic acc = 1'b0;
        b_if.s_valid = 1'b1; b_if.s_data = d; b_if.s_nbytes = nb; b_if.s_last = last;
        for (int t = 0; t < 2000 && !acc; t++) begin
            @(negedge clk); acc = b_if.s_ready;
            @(posedge clk); #1;
        end
        b_if.s_valid = 1'b0;
        if (!acc) check("b_send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic send_c(input logic [63:0] d, input logic [3:0] nb, input logic last);
        logic acc = 1'b0;
        c_if.s_valid = 1'b1; c_if.s_data = d; c_if.s_nbytes = nb; c_if.s_last = last;
        for (int t = 0; t < 2000 && !acc; t++) begin
            @(negedge clk); acc = c_if.s_ready;
            @(posedge clk); #1;
        end
        c_if.s_valid = 1'b0;
        if (!acc) check("c_send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic expect_block(input string tag, input logic [31:0] ew [16],
                                input logic ef, input logic el);
        logic [37:0] e;
        for (int t = 0; t < 3000 && obs_q.size() < 16; t++) begin
            @(posedge clk); #1;
        end
        if (obs_q.size() < 16) begin
            check({tag, "_timeout"}, 64'(obs_q.size()), 64'd16);
            return;
        end
        for (int k = 0; k < 16; k++) begin
            e = obs_q.pop_front();
            check($sformatf("%s_w%0d", tag, k), {26'd0, e}, {26'd0, ef, el, 4'(k), ew[k]});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ew [16];
        logic [37:0] e;
        a_if.s_valid = 0; a_if.s_data = '0; a_if.s_nbytes = '0; a_if.s_last = 0;
        b_if.s_valid = 0; b_if.s_data = '0; b_if.s_nbytes = '0; b_if.s_last = 0;
        c_if.s_valid = 0; c_if.s_data = '0; c_if.s_nbytes = '0; c_if.s_last = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(a_if.s_ready), 64'd1);
        check("rst_m_valid", 64'(a_if.m_valid), 64'd0);
        check("rst_m_word", 64'(a_if.m_word), 64'd0);
        check("rst_idx", 64'(a_if.m_word_idx), 64'd0);
        check("rst_flags", 64'({a_if.m_first_blk, a_if.m_last_blk}), 64'd0);
        check("rst_busy_err", 64'({a_busy, a_err}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // "abc", one byte per beat
        send_a(8'h61, 1'b1, 1'b0); send_a(8'h62, 1'b1, 1'b0); send_a(8'h63, 1'b1, 1'b1);
        ew = '{default: 32'h0}; ew[0] = 32'h61626380; ew[15] = 32'h00000018;
        expect_block("abc", ew, 1'b1, 1'b1);

        // 55 zero bytes: 0x80 and length fit in one block
        for (int i = 0; i < 55; i++) send_a(8'h00, 1'b1, i == 54);
        ew = '{default: 32'h0}; ew[13] = 32'h00000080; ew[15] = 32'h000001B8;
        expect_block("z55", ew, 1'b1, 1'b1);

        // 56 zero bytes: length spills into a second block
        for (int i = 0; i < 56; i++) send_a(8'h00, 1'b1, i == 55);
        ew = '{default: 32'h0}; ew[14] = 32'h80000000;
        expect_block("z56_b1", ew, 1'b1, 1'b0);
        ew = '{default: 32'h0}; ew[15] = 32'h000001C0;
        expect_block("z56_b2", ew, 1'b0, 1'b1);

        // 64 bytes 0xFF: full data block then a fresh padding block
        for (int i = 0; i < 64; i++) send_a(8'hFF, 1'b1, i == 63);
        ew = '{default: 32'hFFFFFFFF};
        expect_block("ff64_b1", ew, 1'b1, 1'b0);
        ew = '{default: 32'h0}; ew[0] = 32'h80000000; ew[15] = 32'h00000200;
        expect_block("ff64_b2", ew, 1'b0, 1'b1);

        // empty message
        send_a(8'h00, 1'b0, 1'b1);
        check("empty_busy_on", 64'(a_busy), 64'd1);
        ew = '{default: 32'h0}; ew[0] = 32'h80000000;
        expect_block("empty", ew, 1'b1, 1'b1);
        check("empty_busy_off", 64'(a_busy), 64'd0);

        // 4-byte beats, partial last beat, random core backpressure
        send_b(32'h00636261, 3'd3, 1'b1);
        ew = '{default: 32'h0}; ew[0] = 32'h61626380; ew[15] = 32'h00000018;
        expect_block("b_abc", ew, 1'b1, 1'b1);

        // 16-bit counter: 8192 bytes wrap the bit length to exactly 0
        for (int i = 0; i < 1024; i++) send_c(64'h0, 4'd8, i == 1023);
        for (int t = 0; t < 5000 && obs_q.size() < 129 * 16; t++) begin
            @(posedge clk); #1;
        end
        check("c_word_count", 64'(obs_q.size()), 64'(129 * 16));
        if (obs_q.size() == 129 * 16) begin
            e = obs_q.pop_front();
            check("c_first_word", {26'd0, e}, {26'd0, 1'b1, 1'b0, 4'd0, 32'h0});
            for (int k = 1; k < 128 * 16; k++) e = obs_q.pop_front();
            ew = '{default: 32'h0}; ew[0] = 32'h80000000;
            expect_block("c_pad", ew, 1'b0, 1'b1);
        end
        obs_q.delete();
        check("c_ovf_set", 64'(c_err), 64'd1);
        send_c(64'h0, 4'd0, 1'b1);
        check("c_ovf_clr", 64'(c_err), 64'd0);
        ew = '{default: 32'h0}; ew[0] = 32'h80000000;
        expect_block("c_empty", ew, 1'b1, 1'b1);

        // backpressure hold, then asynchronous reset in the middle of DRAIN
        a_hold = 1'b1;
        @(posedge clk); #1;
        send_a(8'h61, 1'b1, 1'b0); send_a(8'h62, 1'b1, 1'b0); send_a(8'h63, 1'b1, 1'b1);
        for (int t = 0; t < 200 && !a_if.m_valid; t++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("hold_valid", 64'(a_if.m_valid), 64'd1);
        check("hold_word", 64'(a_if.m_word), 64'h61626380);
        check("hold_idx", 64'(a_if.m_word_idx), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 64'(a_if.m_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_hold = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("rst_mid_no_words", 64'(obs_q.size()), 64'd0);
        check("rst_mid_busy", 64'(a_busy), 64'd0);
        check("rst_mid_s_ready", 64'(a_if.s_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
